// File: rtl/dl_loader.sv
// rtl/dl_loader.sv - ioctl download word FIFO, byte serialiser and per-index loaded tracking.
// Define DL_CHECKSUM_EN to add dl_sum, the 8-bit byte sum of the current download.
module dl_loader_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count != CNT_W'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end
endmodule

module dl_loader #(
  parameter int NUM_TARGETS = 4,
  parameter int ADDR_W      = 16,
  parameter int IN_W        = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   ioctl_download,
  input  logic [7:0]             ioctl_index,
  input  logic [ADDR_W-1:0]      ioctl_addr,
  input  logic [IN_W-1:0]        ioctl_dout,
  input  logic                   ioctl_wr,
  output logic                   ioctl_wait,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [7:0]             mem_dout,
  output logic                   mem_we,
  output logic [NUM_TARGETS-1:0] mem_sel,
  input  logic                   mem_ack,
  output logic [NUM_TARGETS-1:0] loaded,
  output logic                   busy,
  output logic                   cpu_hold,
  output logic                   overflow
`ifdef DL_CHECKSUM_EN
  ,
  output logic [7:0]             dl_sum
`endif
);
  localparam int ENT_W = 8 + ADDR_W + IN_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [8:0] NT9 = 9'(NUM_TARGETS);

  typedef enum logic [1:0] {IDLE, B0, B1} state_t;

  state_t              state;
  state_t              state_nx;
  logic [ENT_W-1:0]    head;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_empty;
  logic                fifo_full;
  logic                push_req;
  logic                fifo_pop;
  logic                load_hold;
  logic [7:0]          head_index;
  logic [7:0]          hold_index;
  logic [ADDR_W-1:0]   hold_addr;
  logic [IN_W-1:0]     hold_data;
  logic                dl_prev;
  logic [7:0]          dl_index;
  logic                pending;
  logic                dl_rise;
  logic                dl_fall;
  logic                set_loaded;

  assign push_req   = ioctl_wr && ioctl_download;
  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign ioctl_wait = (fifo_count >= CNT_W'(FIFO_DEPTH - 1));
  assign head_index = head[ENT_W-1 -: 8];

  dl_loader_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_sys),
    .rst       (reset),
    .push      (push_req),
    .push_data ({ioctl_index, ioctl_addr, ioctl_dout}),
    .pop       (fifo_pop),
    .head      (head),
    .count     (fifo_count)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) overflow <= 1'b0;
    else if (push_req && fifo_full) overflow <= 1'b1;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      hold_index <= '0;
      hold_addr  <= '0;
      hold_data  <= '0;
    end else begin
      state <= state_nx;
      if (load_hold) begin
        hold_index <= head_index;
        hold_addr  <= head[IN_W +: ADDR_W];
        hold_data  <= head[IN_W-1:0];
      end
    end
  end

  // Out-of-range entries are popped in IDLE and simply never leave it.
  always_comb begin
    state_nx  = state;
    fifo_pop  = 1'b0;
    load_hold = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_dout  = '0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          load_hold = 1'b1;
          if ({1'b0, head_index} < NT9) state_nx = B0;
        end
      end
      B0: begin
        mem_we   = 1'b1;
        mem_addr = hold_addr;
        mem_dout = hold_data[7:0];
        if (mem_ack) state_nx = (IN_W == 16) ? B1 : IDLE;
      end
      B1: begin
        mem_we   = 1'b1;
        mem_addr = hold_addr + ADDR_W'(1);
        mem_dout = hold_data[IN_W-1 -: 8];
        if (mem_ack) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    mem_sel = '0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      mem_sel[i] = mem_we && (hold_index == 8'(i));
    end
  end

  assign busy     = !fifo_empty || (state != IDLE);
  assign cpu_hold = ioctl_download || busy || !loaded[0];

  assign dl_rise    = ioctl_download && !dl_prev;
  assign dl_fall    = !ioctl_download && dl_prev;
  assign set_loaded = !dl_rise && !dl_fall && pending && !busy;

  // A new rising edge supersedes any drain wait still pending for the previous index.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dl_prev  <= 1'b0;
      dl_index <= '0;
      pending  <= 1'b0;
      loaded   <= '0;
    end else begin
      dl_prev <= ioctl_download;
      if (dl_rise) begin
        dl_index <= ioctl_index;
        pending  <= 1'b0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
          if (ioctl_index == 8'(i)) loaded[i] <= 1'b0;
        end
      end else if (dl_fall) begin
        pending <= 1'b1;
      end else if (set_loaded) begin
        pending <= 1'b0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
          if (dl_index == 8'(i)) loaded[i] <= 1'b1;
        end
      end
    end
  end

`ifdef DL_CHECKSUM_EN
  logic sum_frozen;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dl_sum     <= '0;
      sum_frozen <= 1'b0;
    end else if (dl_rise) begin
      dl_sum     <= '0;
      sum_frozen <= 1'b0;
    end else begin
      if (mem_we && mem_ack && !sum_frozen) dl_sum <= dl_sum + mem_dout;
      if (set_loaded) sum_frozen <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_dl_loader.sv
// tb/tb_dl_loader.sv - directed scoreboard bench for dl_loader
module tb_dl_loader;
  localparam int NT = 4;
  localparam int AW = 16;
  localparam int IW = 16;

  logic          clk_sys = 1'b0;
  logic          reset = 1'b1;
  logic          ioctl_download = 1'b0;
  logic [7:0]    ioctl_index = '0;
  logic [AW-1:0] ioctl_addr = '0;
  logic [IW-1:0] ioctl_dout = '0;
  logic          ioctl_wr = 1'b0;
  logic          mem_ack = 1'b0;
  logic          ioctl_wait;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_dout;
  logic          mem_we;
  logic [NT-1:0] mem_sel;
  logic [NT-1:0] loaded;
  logic          busy;
  logic          cpu_hold;
  logic          overflow;
`ifdef DL_CHECKSUM_EN
  logic [7:0]    dl_sum;
`endif

  int checks = 0;
  int errors = 0;
  int we_cycles = 0;
  int we_snap;
  int n;
  logic last_hold;
  logic [27:0] sb[$];

  dl_loader #(
    .NUM_TARGETS (NT),
    .ADDR_W      (AW),
    .IN_W        (IW),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wr       (ioctl_wr),
    .ioctl_wait     (ioctl_wait),
    .mem_addr       (mem_addr),
    .mem_dout       (mem_dout),
    .mem_we         (mem_we),
    .mem_sel        (mem_sel),
    .mem_ack        (mem_ack),
    .loaded         (loaded),
    .busy           (busy),
    .cpu_hold       (cpu_hold),
    .overflow       (overflow)
`ifdef DL_CHECKSUM_EN
    ,
    .dl_sum         (dl_sum)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: handshakes are scored at the falling edge, inputs change 1 ns after the rising edge.
  task automatic step();
    logic [27:0] e;
    @(negedge clk_sys);
    if (mem_we) we_cycles++;
    if (mem_we && mem_ack) begin
      if (sb.size() == 0) begin
        check("unexpected_write", {4'b0, mem_addr, mem_dout, mem_sel}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("mem_write", {4'b0, mem_addr, mem_dout, mem_sel}, {4'b0, e});
      end
    end
    @(posedge clk_sys);
    #1;
  endtask

  task automatic push_word(input logic [15:0] addr, input logic [15:0] data,
                           input bit expect_write, input logic [3:0] sel);
    ioctl_addr = addr;
    ioctl_dout = data;
    ioctl_wr   = 1'b1;
    step();
    ioctl_wr   = 1'b0;
    if (expect_write) begin
      sb.push_back({addr, data[7:0], sel});
      sb.push_back({addr + 16'd1, data[15:8], sel});
    end
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    step();
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    step();
  endtask

  task automatic wait_loaded(input int idx, input string tag);
    int k = 0;
    last_hold = cpu_hold;
    while (loaded[idx] !== 1'b1 && k < 300) begin
      last_hold = cpu_hold;
      step();
      k++;
    end
    check({tag, "_loaded"}, 32'(loaded[idx]), 32'd1);
  endtask

  initial begin
    // Reset state
    step();
    step();
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_dout", 32'(mem_dout), 32'd0);
    check("rst_mem_sel", 32'(mem_sel), 32'd0);
    check("rst_wait", 32'(ioctl_wait), 32'd0);
    check("rst_loaded", 32'(loaded), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    reset = 1'b0;
    step();

    // Three words to index 0, ack always high
    mem_ack = 1'b1;
    start_dl(8'd0);
    check("t1_loaded_clear", 32'(loaded), 32'd0);
    push_word(16'h0000, 16'h2211, 1'b1, 4'b0001);
    push_word(16'h0002, 16'h4433, 1'b1, 4'b0001);
    push_word(16'h0004, 16'h6655, 1'b1, 4'b0001);
    end_dl();
    wait_loaded(0, "t1");
    check("t1_hold_before", 32'(last_hold), 32'd1);
    check("t1_hold_after", 32'(cpu_hold), 32'd0);
    check("t1_sb_empty", 32'(sb.size()), 32'd0);

    // Stalled target, back-pressure, in-flight word, then overflow
    mem_ack = 1'b0;
    start_dl(8'd0);
    check("t2_loaded_clear", 32'(loaded[0]), 32'd0);
    check("t2_cpu_hold", 32'(cpu_hold), 32'd1);
    for (int k = 0; k < 5; k++) begin
      push_word(16'h0100 + 16'(2 * k), {8'hB0 + 8'(k), 8'hA0 + 8'(k)}, 1'b1, 4'b0001);
      if (k == 2) check("t2_wait_cnt2", 32'(ioctl_wait), 32'd0);
      if (k == 3) check("t2_wait_cnt3", 32'(ioctl_wait), 32'd1);
    end
    check("t2_no_overflow", 32'(overflow), 32'd0);
    check("t2_wait_full", 32'(ioctl_wait), 32'd1);
    push_word(16'h010A, 16'hEEFF, 1'b0, 4'b0001);
    check("t3_overflow", 32'(overflow), 32'd1);
    for (int k = 0; k < 10; k++) begin
      check("t2_hold_we", 32'(mem_we), 32'd1);
      check("t2_hold_addr", 32'(mem_addr), 32'h0100);
      check("t2_hold_dout", 32'(mem_dout), 32'hA0);
      step();
    end
    mem_ack = 1'b1;
    end_dl();
    wait_loaded(0, "t3");
    check("t3_sb_empty", 32'(sb.size()), 32'd0);
    check("t3_overflow_sticky", 32'(overflow), 32'd1);

    // Out-of-range index
    we_snap = we_cycles;
    start_dl(8'd7);
    push_word(16'h0300, 16'h1234, 1'b0, 4'b0000);
    push_word(16'h0302, 16'h5678, 1'b0, 4'b0000);
    end_dl();
    n = 0;
    while (busy && n < 50) begin step(); n++; end
    check("t4_busy", 32'(busy), 32'd0);
    step();
    step();
    check("t4_no_we", 32'(we_cycles), 32'(we_snap));
    check("t4_loaded", 32'(loaded), 32'b0001);
    check("t4_cpu_hold", 32'(cpu_hold), 32'd0);

    // Address wrap
    start_dl(8'd1);
    push_word(16'hFFFF, 16'h7788, 1'b1, 4'b0010);
    end_dl();
    wait_loaded(1, "t5");
    check("t5_loaded", 32'(loaded), 32'b0011);
    check("t5_sb_empty", 32'(sb.size()), 32'd0);

`ifdef DL_CHECKSUM_EN
    start_dl(8'd3);
    check("cs_cleared", 32'(dl_sum), 32'd0);
    push_word(16'h0000, 16'h9080, 1'b1, 4'b1000);
    end_dl();
    wait_loaded(3, "cs");
    check("cs_sum", 32'(dl_sum), 32'h10);
`endif

    // Reset in the middle of B1
    mem_ack = 1'b0;
    start_dl(8'd2);
    push_word(16'h0020, 16'h5566, 1'b1, 4'b0100);
    n = 0;
    while (!mem_we && n < 20) begin step(); n++; end
    check("t6_b0_we", 32'(mem_we), 32'd1);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("t6_b1_addr", 32'(mem_addr), 32'h0021);
    check("t6_b1_dout", 32'(mem_dout), 32'h55);
    reset = 1'b1;
    ioctl_download = 1'b0;
    #1;
    check("t6_we", 32'(mem_we), 32'd0);
    check("t6_addr", 32'(mem_addr), 32'd0);
    check("t6_dout", 32'(mem_dout), 32'd0);
    check("t6_sel", 32'(mem_sel), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_loaded", 32'(loaded), 32'd0);
    check("t6_overflow", 32'(overflow), 32'd0);
    check("t6_cpu_hold", 32'(cpu_hold), 32'd1);
    sb.delete();
    step();
    step();
    reset = 1'b0;
    step();

    // Normal operation after reset
    mem_ack = 1'b1;
    start_dl(8'd0);
    push_word(16'h0040, 16'hCDAB, 1'b1, 4'b0001);
    end_dl();
    wait_loaded(0, "t7");
    check("t7_sb_empty", 32'(sb.size()), 32'd0);
    check("t7_loaded", 32'(loaded), 32'b0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
